// File: rtl/hcsr04_pkg.sv
// Shared definitions for the HC-SR04 interface: FSM state codes,
// microsecond-to-cycle conversion and the BCD digit ceiling.
package hcsr04_pkg;

    // FSM state codes, also exported on db_estado
    typedef enum logic [3:0] {
        ST_INICIAL        = 4'd0,
        ST_PREPARACAO     = 4'd1,
        ST_ENVIA_TRIGGER  = 4'd2,
        ST_ESPERA_ECHO    = 4'd3,
        ST_MEDINDO        = 4'd4,
        ST_ARREDONDA      = 4'd5,
        ST_ARMAZENA       = 4'd6,
        ST_FINAL          = 4'd7,
        ST_ESPERA_PERIODO = 4'd8,
        ST_ERRO_TIMEOUT   = 4'd15
    } estado_t;

    // Largest value a single BCD digit may hold
    localparam logic [3:0] BCD_MAX = 4'd9;

    // Converts a time in microseconds to clock cycles at elaboration
    function automatic longint unsigned us_to_cycles(input longint unsigned us,
                                                     input longint unsigned freq);
        return (us * freq) / 64'd1_000_000;
    endfunction

endpackage

// File: rtl/contador_cm_bcd.sv
// Echo-width to centimetre converter: a residual counter that wraps every
// CLKS_PER_CM cycles and a DIGITS-digit BCD counter that saturates at all 9s.
module contador_cm_bcd
    import hcsr04_pkg::*;
#(
    parameter int unsigned CLKS_PER_CM = 2941,
    parameter int unsigned DIGITS      = 3
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  zera,
    input  logic                  conta,
    input  logic                  arredonda,
    output logic [4*DIGITS-1:0]   valor,
    output logic                  residuo_meio
);

    localparam int RW = (CLKS_PER_CM > 1) ? $clog2(CLKS_PER_CM) : 1;
    localparam logic [RW-1:0] ULTIMO = RW'(CLKS_PER_CM - 1);
    localparam logic [RW-1:0] MEIO   = RW'(CLKS_PER_CM / 2);
    localparam logic [4*DIGITS-1:0] VALOR_MAX = {DIGITS{BCD_MAX}};

    logic [RW-1:0]     resid_reg;
    logic [3:0]        digito_reg [DIGITS];
    logic [DIGITS-1:0] carry;
    logic              incrementa;
    logic              saturado;

    assign saturado     = (valor == VALOR_MAX);
    assign incrementa   = (conta && (resid_reg == ULTIMO)) || arredonda;
    assign residuo_meio = (resid_reg >= MEIO);
    // Once saturated, neither wraps nor the round-up can move the count
    assign carry[0]     = incrementa & ~saturado;

    // Residual cycles within the current centimetre
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            resid_reg <= '0;
        end else if (zera) begin
            resid_reg <= '0;
        end else if (conta) begin
            resid_reg <= (resid_reg == ULTIMO) ? '0 : resid_reg + 1'b1;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_digito
            if (gi < DIGITS - 1) begin : g_carry
                // Ripple carry into the next digit when this one rolls over
                assign carry[gi+1] = carry[gi] & (digito_reg[gi] == BCD_MAX);
            end

            // One BCD digit, rolling 9 -> 0 on carry-in
            always_ff @(posedge clock or negedge reset) begin
                if (!reset) begin
                    digito_reg[gi] <= 4'd0;
                end else if (zera) begin
                    digito_reg[gi] <= 4'd0;
                end else if (carry[gi]) begin
                    digito_reg[gi] <= (digito_reg[gi] == BCD_MAX) ? 4'd0 : digito_reg[gi] + 4'd1;
                end
            end

            assign valor[4*gi +: 4] = digito_reg[gi];
        end
    endgenerate

endmodule

// File: rtl/interface_hcsr04_param.sv
// HC-SR04 interface: trigger generation, echo timing with start/length
// timeouts, rounding to the nearest cm and optional periodic measurement.
module interface_hcsr04_param
    import hcsr04_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ     = 50_000_000,
    parameter int unsigned TRIG_US         = 10,
    parameter int unsigned CLKS_PER_CM     = 2941,
    parameter int unsigned DIGITS          = 3,
    parameter int unsigned TIMEOUT_ECHO_US = 2000,
    parameter int unsigned MAX_ECHO_US     = 65000,
    parameter int unsigned PERIODO_US      = 100000
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  medir,
    input  logic                  modo,
    input  logic                  echo,
    output logic                  trigger,
    output logic [4*DIGITS-1:0]   medida,
    output logic                  pronto,
    output logic                  erro,
    output logic [3:0]            db_estado
);

    localparam longint unsigned TRIG_CYC     = us_to_cycles(64'(TRIG_US), 64'(CLK_FREQ_HZ));
    localparam longint unsigned TIMEOUT_CYC  = us_to_cycles(64'(TIMEOUT_ECHO_US), 64'(CLK_FREQ_HZ));
    localparam longint unsigned MAX_ECHO_CYC = us_to_cycles(64'(MAX_ECHO_US), 64'(CLK_FREQ_HZ));
    localparam longint unsigned PERIODO_CYC  = us_to_cycles(64'(PERIODO_US), 64'(CLK_FREQ_HZ));
    localparam longint unsigned MAIOR_AUX    = (PERIODO_CYC > MAX_ECHO_CYC) ? PERIODO_CYC : MAX_ECHO_CYC;
    localparam longint unsigned MAIOR_CYC    = (MAIOR_AUX > TIMEOUT_CYC) ? MAIOR_AUX : TIMEOUT_CYC;
    localparam int CW = $clog2(MAIOR_CYC + 1);

    localparam logic [CW-1:0] TRIG_FIM     = CW'(TRIG_CYC - 1);
    localparam logic [CW-1:0] TIMEOUT_FIM  = CW'(TIMEOUT_CYC - 1);
    localparam logic [CW-1:0] MAX_ECHO_FIM = CW'(MAX_ECHO_CYC - 1);
    // Two cycles go to the preparacao hop before the next trigger rise
    localparam logic [CW-1:0] PERIODO_FIM  = CW'(PERIODO_CYC - 2);
    localparam logic [4*DIGITS-1:0] MEDIDA_MAX = {DIGITS{BCD_MAX}};

    estado_t              state_reg, state_next;
    logic [CW-1:0]        tempo_reg;
    logic [CW-1:0]        periodo_reg;
    logic [4*DIGITS-1:0]  medida_reg;
    logic [4*DIGITS-1:0]  valor;
    logic                 erro_reg, erro_longo_reg;
    logic                 trigger_reg, pronto_reg;
    logic                 echo_meta_reg, echo_sync_reg, echo_prev_reg;
    logic                 echo_sobe;
    logic                 zera, conta, arredonda, residuo_meio;

    assign echo_sobe = echo_sync_reg & ~echo_prev_reg;
    assign trigger   = trigger_reg;
    assign pronto    = pronto_reg;
    assign erro      = erro_reg;
    assign medida    = medida_reg;
    assign db_estado = state_reg;

    // Two-flop synchroniser for echo plus one more stage for edge detection
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            echo_meta_reg <= 1'b0;
            echo_sync_reg <= 1'b0;
            echo_prev_reg <= 1'b0;
        end else begin
            echo_meta_reg <= echo;
            echo_sync_reg <= echo_meta_reg;
            echo_prev_reg <= echo_sync_reg;
        end
    end

    // FSM state register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state_reg <= ST_INICIAL;
        else        state_reg <= state_next;
    end

    // Next-state and counter-control decode
    always_comb begin
        state_next = state_reg;
        zera       = 1'b0;
        conta      = 1'b0;
        arredonda  = 1'b0;
        case (state_reg)
            ST_INICIAL:       if (medir) state_next = ST_PREPARACAO;
            ST_PREPARACAO: begin
                zera       = 1'b1;
                state_next = ST_ENVIA_TRIGGER;
            end
            ST_ENVIA_TRIGGER: if (tempo_reg == TRIG_FIM) state_next = ST_ESPERA_ECHO;
            ST_ESPERA_ECHO: begin
                // The rise cycle itself is the first counted cycle of the echo
                if (echo_sobe) begin
                    conta      = 1'b1;
                    state_next = ST_MEDINDO;
                end else if (tempo_reg == TIMEOUT_FIM) begin
                    state_next = ST_ERRO_TIMEOUT;
                end
            end
            ST_MEDINDO: begin
                if (!echo_sync_reg) begin
                    state_next = ST_ARREDONDA;
                end else begin
                    conta = 1'b1;
                    if (tempo_reg == MAX_ECHO_FIM) state_next = ST_ERRO_TIMEOUT;
                end
            end
            ST_ARREDONDA: begin
                arredonda  = residuo_meio;
                state_next = ST_ARMAZENA;
            end
            ST_ARMAZENA:      state_next = ST_FINAL;
            ST_FINAL:         state_next = modo ? ST_ESPERA_PERIODO : ST_INICIAL;
            ST_ESPERA_PERIODO: begin
                if (!modo)                           state_next = ST_INICIAL;
                else if (periodo_reg >= PERIODO_FIM) state_next = ST_PREPARACAO;
            end
            ST_ERRO_TIMEOUT:  state_next = ST_FINAL;
            default:          state_next = ST_INICIAL;
        endcase
    end

    // Per-state timer and trigger-to-trigger period timer
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            tempo_reg   <= '0;
            periodo_reg <= '0;
        end else begin
            if (state_next != state_reg) tempo_reg <= '0;
            else if (tempo_reg != '1)    tempo_reg <= tempo_reg + 1'b1;

            if (state_next == ST_ENVIA_TRIGGER && state_reg != ST_ENVIA_TRIGGER) periodo_reg <= '0;
            else if (periodo_reg != '1)                                          periodo_reg <= periodo_reg + 1'b1;
        end
    end

    // Result and error flag, owned by armazena / erro_timeout / preparacao
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            medida_reg     <= '0;
            erro_reg       <= 1'b0;
            erro_longo_reg <= 1'b0;
        end else begin
            if (state_next == ST_ERRO_TIMEOUT && state_reg != ST_ERRO_TIMEOUT)
                erro_longo_reg <= (state_reg == ST_MEDINDO);
            case (state_reg)
                ST_PREPARACAO: erro_reg <= 1'b0;
                ST_ARMAZENA:   medida_reg <= valor;
                ST_ERRO_TIMEOUT: begin
                    erro_reg <= 1'b1;
                    if (erro_longo_reg) medida_reg <= MEDIDA_MAX;
                end
                default: ;
            endcase
        end
    end

    // Registered pin outputs decoded from the upcoming state
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            trigger_reg <= 1'b0;
            pronto_reg  <= 1'b0;
        end else begin
            trigger_reg <= (state_next == ST_ENVIA_TRIGGER);
            pronto_reg  <= (state_next == ST_FINAL);
        end
    end

    contador_cm_bcd #(
        .CLKS_PER_CM (CLKS_PER_CM),
        .DIGITS      (DIGITS)
    ) u_contador (
        .clock        (clock),
        .reset        (reset),
        .zera         (zera),
        .conta        (conta),
        .arredonda    (arredonda),
        .valor        (valor),
        .residuo_meio (residuo_meio)
    );

endmodule
